// File: rtl/riscv_csr_access.sv
// CSR access initiator: executes one CSRRW/S/C (register or immediate form) at a time.
// It reads the old CSR value, writes the new value when needed and returns the old value for rd.
module riscv_csr_access #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_src,
  input  logic              req_src_is_x0,
  input  logic              req_rd_is_x0,
  output logic              csr_rd_en,
  output logic [ADDR_W-1:0] csr_rd_addr,
  input  logic [XLEN-1:0]   csr_rd_data,
  input  logic              csr_rd_err,
  output logic              csr_wr_en,
  output logic [ADDR_W-1:0] csr_wr_addr,
  output logic [XLEN-1:0]   csr_wr_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_data,
  output logic              rsp_illegal,
  output logic [2:0]        dbg_state
);

  // Handshakes: a transfer happens on a posedge where valid && ready. The request is taken
  // only in IDLE; the response is held stable from rsp_valid rise until rsp_ready is seen.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_CAPTURE = 3'd2,
    S_WRITE   = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [1:0]        kind_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   src_q;
  logic              src_x0_q;
  logic [XLEN-1:0]   new_q;
  logic [XLEN-1:0]   rsp_data_q;
  logic              rsp_illegal_q;

  logic              req_bad_op;
  logic              req_wr_only;
  logic              req_ro;
  logic [XLEN-1:0]   req_src_m;
  logic              wr_needed;
  logic              cap_illegal;
  logic [XLEN-1:0]   new_val;

  // Immediate forms carry a 5-bit zimm; upper bits of req_src are not trusted.
  assign req_src_m   = req_op[2] ? {{(XLEN-5){1'b0}}, req_src[4:0]} : req_src;
  assign req_bad_op  = (req_op[1:0] == 2'b00);
  assign req_wr_only = (req_op[1:0] == 2'b01) && req_rd_is_x0;
  assign req_ro      = (req_addr[ADDR_W-1 -: 2] == 2'b11);

  assign wr_needed   = (kind_q == 2'b01) || !src_x0_q;
  assign cap_illegal = csr_rd_err || (wr_needed && (addr_q[ADDR_W-1 -: 2] == 2'b11));

  always_comb begin
    new_val = src_q;
    case (kind_q)
      2'b10:   new_val = csr_rd_data | src_q;
      2'b11:   new_val = csr_rd_data & ~src_q;
      default: new_val = src_q;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (req_bad_op || (req_wr_only && req_ro)) state_nxt = S_RESP;
          else if (req_wr_only)                      state_nxt = S_WRITE;
          else                                       state_nxt = S_READ;
        end
      end
      S_READ:    state_nxt = S_CAPTURE;
      S_CAPTURE: begin
        if (cap_illegal)    state_nxt = S_RESP;
        else if (wr_needed) state_nxt = S_WRITE;
        else                state_nxt = S_RESP;
      end
      S_WRITE:   state_nxt = S_RESP;
      S_RESP:    if (rsp_ready) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      kind_q        <= 2'b00;
      addr_q        <= '0;
      src_q         <= '0;
      src_x0_q      <= 1'b0;
      new_q         <= '0;
      rsp_data_q    <= '0;
      rsp_illegal_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && req_valid) begin
        kind_q        <= req_op[1:0];
        addr_q        <= req_addr;
        src_q         <= req_src_m;
        src_x0_q      <= req_src_is_x0;
        new_q         <= req_src_m;
        rsp_data_q    <= '0;
        rsp_illegal_q <= req_bad_op || (req_wr_only && req_ro);
      end else if (state == S_CAPTURE) begin
        new_q         <= new_val;
        rsp_data_q    <= csr_rd_data;
        rsp_illegal_q <= cap_illegal;
      end
    end
  end

  // Strobes decode straight from state so an async reset removes them at once.
  assign req_ready   = (state == S_IDLE);
  assign csr_rd_en   = (state == S_READ);
  assign csr_wr_en   = (state == S_WRITE);
  assign csr_rd_addr = addr_q;
  assign csr_wr_addr = addr_q;
  assign csr_wr_data = new_q;
  assign rsp_valid   = (state == S_RESP);
  assign rsp_data    = rsp_data_q;
  assign rsp_illegal = rsp_illegal_q;
  assign dbg_state   = state;

endmodule

// File: tb/tb_riscv_csr_access.sv
// Directed bench for riscv_csr_access: cycle-exact checks of strobes, write data and responses
// for each CSR instruction form, illegal cases, response back-pressure and mid-op reset.
module tb_riscv_csr_access;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [11:0] req_addr;
  logic [31:0] req_src;
  logic        req_src_is_x0;
  logic        req_rd_is_x0;
  logic        csr_rd_en;
  logic [11:0] csr_rd_addr;
  logic [31:0] csr_rd_data;
  logic        csr_rd_err;
  logic        csr_wr_en;
  logic [11:0] csr_wr_addr;
  logic [31:0] csr_wr_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_illegal;
  logic [2:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  riscv_csr_access #(.XLEN(32), .ADDR_W(12)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .req_src(req_src), .req_src_is_x0(req_src_is_x0), .req_rd_is_x0(req_rd_is_x0),
    .csr_rd_en(csr_rd_en), .csr_rd_addr(csr_rd_addr), .csr_rd_data(csr_rd_data),
    .csr_rd_err(csr_rd_err), .csr_wr_en(csr_wr_en), .csr_wr_addr(csr_wr_addr),
    .csr_wr_data(csr_wr_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_illegal(rsp_illegal), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request for one edge; returns #1 into cycle 1 after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] src,
                       input logic src_x0, input logic rd_x0);
    req_op        = op;
    req_addr      = addr;
    req_src       = src;
    req_src_is_x0 = src_x0;
    req_rd_is_x0  = rd_x0;
    req_valid     = 1'b1;
    step();
    req_valid     = 1'b0;
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_op = 3'b000; req_addr = '0; req_src = '0;
    req_src_is_x0 = 1'b0; req_rd_is_x0 = 1'b0; csr_rd_data = '0; csr_rd_err = 1'b0;
    rsp_ready = 1'b1;
    #3;
    chk("rst_rd_en", csr_rd_en, 1'b0);
    chk("rst_wr_en", csr_wr_en, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_rsp_illegal", rsp_illegal, 1'b0);
    chk("rst_wr_addr", csr_wr_addr, 32'h0);
    chk("rst_wr_data", csr_wr_data, 32'h0);
    step();
    rst = 1'b1;
    step();
    chk("rst_req_ready", req_ready, 1'b1);

    // CSRRS 0x300 src=0x8 old=0x1800: read c1, write c3 0x1808, response c4
    csr_rd_data = 32'h0000_1800;
    issue(3'b010, 12'h300, 32'h8, 1'b0, 1'b0);
    chk("rs_c1_rd_en", csr_rd_en, 1'b1);
    chk("rs_c1_rd_addr", csr_rd_addr, 32'h300);
    chk("rs_c1_req_ready", req_ready, 1'b0);
    step();
    chk("rs_c2_rd_en", csr_rd_en, 1'b0);
    chk("rs_c2_wr_en", csr_wr_en, 1'b0);
    step();
    chk("rs_c3_wr_en", csr_wr_en, 1'b1);
    chk("rs_c3_wr_addr", csr_wr_addr, 32'h300);
    chk("rs_c3_wr_data", csr_wr_data, 32'h1808);
    chk("rs_c3_rsp_valid", rsp_valid, 1'b0);
    step();
    chk("rs_c4_rsp_valid", rsp_valid, 1'b1);
    chk("rs_c4_rsp_data", rsp_data, 32'h1800);
    chk("rs_c4_illegal", rsp_illegal, 1'b0);
    chk("rs_c4_wr_en", csr_wr_en, 1'b0);
    step();
    chk("rs_idle_ready", req_ready, 1'b1);
    chk("rs_idle_rsp_valid", rsp_valid, 1'b0);

    // CSRRC with rs1=x0: read only, response at c3
    csr_rd_data = 32'h88;
    issue(3'b011, 12'h300, 32'h0, 1'b1, 1'b0);
    chk("rc0_c1_rd_en", csr_rd_en, 1'b1);
    step();
    step();
    chk("rc0_c3_rsp_valid", rsp_valid, 1'b1);
    chk("rc0_c3_rsp_data", rsp_data, 32'h88);
    chk("rc0_c3_wr_en", csr_wr_en, 1'b0);
    step();

    // CSRRWI rd=x0, zimm=0x1F with junk upper src bits: write only at c1, response c2 data 0
    issue(3'b101, 12'h300, 32'hFFFF_FFFF, 1'b0, 1'b1);
    chk("rwi_c1_rd_en", csr_rd_en, 1'b0);
    chk("rwi_c1_wr_en", csr_wr_en, 1'b1);
    chk("rwi_c1_wr_data", csr_wr_data, 32'h1F);
    step();
    chk("rwi_c2_rsp_valid", rsp_valid, 1'b1);
    chk("rwi_c2_rsp_data", rsp_data, 32'h0);
    chk("rwi_c2_wr_en", csr_wr_en, 1'b0);
    step();

    // CSRRW to read-only 0xC00: read happens, no write, illegal at c3
    csr_rd_data = 32'h1234;
    issue(3'b001, 12'hC00, 32'h5, 1'b0, 1'b0);
    chk("ro_c1_rd_en", csr_rd_en, 1'b1);
    step();
    step();
    chk("ro_c3_wr_en", csr_wr_en, 1'b0);
    chk("ro_c3_rsp_valid", rsp_valid, 1'b1);
    chk("ro_c3_illegal", rsp_illegal, 1'b1);
    chk("ro_c3_rsp_data", rsp_data, 32'h1234);
    step();

    // op=100: illegal at c1, no CSR access
    issue(3'b100, 12'h300, 32'h7, 1'b0, 1'b0);
    chk("bad_c1_rd_en", csr_rd_en, 1'b0);
    chk("bad_c1_rsp_valid", rsp_valid, 1'b1);
    chk("bad_c1_illegal", rsp_illegal, 1'b1);
    chk("bad_c1_rsp_data", rsp_data, 32'h0);
    step();

    // CSRRW rd=x0 to 0xC00: illegal, never writes
    issue(3'b001, 12'hC00, 32'h5, 1'b0, 1'b1);
    chk("rox0_c1_wr_en", csr_wr_en, 1'b0);
    chk("rox0_c1_rsp_valid", rsp_valid, 1'b1);
    chk("rox0_c1_illegal", rsp_illegal, 1'b1);
    step();

    // CSRRS to unimplemented CSR: read error makes it illegal, no write
    csr_rd_data = 32'hDEAD_BEEF;
    csr_rd_err  = 1'b1;
    issue(3'b010, 12'h7FF, 32'h1, 1'b0, 1'b0);
    step();
    step();
    chk("err_c3_wr_en", csr_wr_en, 1'b0);
    chk("err_c3_rsp_valid", rsp_valid, 1'b1);
    chk("err_c3_illegal", rsp_illegal, 1'b1);
    csr_rd_err = 1'b0;
    step();

    // CSRRCI zimm=0x3, old=0xF: write 0xC at c3
    csr_rd_data = 32'hF;
    issue(3'b111, 12'h340, 32'h3, 1'b0, 1'b0);
    step();
    step();
    chk("rci_c3_wr_en", csr_wr_en, 1'b1);
    chk("rci_c3_wr_data", csr_wr_data, 32'hC);
    chk("rci_c3_wr_addr", csr_wr_addr, 32'h340);
    step();
    chk("rci_c4_rsp_data", rsp_data, 32'hF);
    chk("rci_c4_illegal", rsp_illegal, 1'b0);
    step();

    // Back-pressure: rsp_ready low 3 cycles, new request presented meanwhile must be ignored
    csr_rd_data = 32'hABCD;
    rsp_ready   = 1'b0;
    issue(3'b010, 12'h341, 32'h0, 1'b1, 1'b0);
    step();
    step();
    chk("bp_c3_rsp_valid", rsp_valid, 1'b1);
    req_op = 3'b001; req_addr = 12'h305; req_src = 32'h55; req_src_is_x0 = 1'b0;
    req_rd_is_x0 = 1'b1; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_valid", rsp_valid, 1'b1);
      chk("bp_hold_data", rsp_data, 32'hABCD);
      chk("bp_hold_ready", req_ready, 1'b0);
      chk("bp_hold_wr_en", csr_wr_en, 1'b0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    chk("bp_release_ready", req_ready, 1'b1);
    chk("bp_release_valid", rsp_valid, 1'b0);
    step();
    chk("bp_still_idle", dbg_state, 3'd0);

    // Reset asserted during WRITE: strobe drops at once, no response afterwards
    csr_rd_data = 32'h0;
    issue(3'b001, 12'h305, 32'h80, 1'b0, 1'b0);
    step();
    step();
    chk("mr_c3_wr_en", csr_wr_en, 1'b1);
    rst = 1'b0;
    #1;
    chk("mr_wr_en_drop", csr_wr_en, 1'b0);
    chk("mr_rsp_valid", rsp_valid, 1'b0);
    chk("mr_wr_data", csr_wr_data, 32'h0);
    step();
    rst = 1'b1;
    step();
    chk("mr_after_ready", req_ready, 1'b1);
    chk("mr_after_rsp_valid", rsp_valid, 1'b0);
    chk("mr_after_wr_en", csr_wr_en, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
